regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Arbitration and initialisation controller for the shared register-file write port of the single-cycle core. It sits between the core's writeback path (ALU result, memory data or PC+4 for Jal) and the register file inside the decode stage, and multiplexes in a debug host that reads and writes registers over a req/ack handshake. After reset it walks the register file clearing every register. During normal running it guarantees the debug host bounded wait by stalling the core when needed.

## Interface
Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, register data width
- STARVE_LIMIT, 4, debug wait cycles before the core is forced to stall (1..15)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; asserting it forces reset state immediately
- cpu_wen  in  1  core writeback request this cycle (RegWrite)
- cpu_waddr  in  ADDR_W  core destination register (after RegDst/Jal selection)
- cpu_wdata  in  DATA_W  core writeback data (after MemtoReg/Jal selection)
- cpu_stall  out  1  core must hold PC and its writeback request this cycle
- dbg_req  in  1  debug request; held with dbg_we/addr/wdata stable until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  ADDR_W  debug register address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read data; valid when dbg_ack=1, held until the next debug grant
- rf_wen  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- rf_dbg_raddr  out  ADDR_W  register-file third (debug) read port address
- rf_dbg_rdata  in  DATA_W  combinational read data for rf_dbg_raddr
- clearing  out  1  high while the clear sequence runs

## Operation
- States: CLEAR, RUN, ACK.
- Reset (reset=0): state=CLEAR, clr_cnt=1, wait_cnt=0, dbg_ack=0, dbg_rdata=0, cpu_stall=1, clearing=1.
- CLEAR: rf_wen=1, rf_waddr=clr_cnt, rf_wdata=0. clr_cnt increments each cycle. Register 0 is skipped. When clr_cnt=31, the next state is RUN. cpu_stall=1 and clearing=1 throughout. dbg_req is ignored but wait_cnt does not count.
- RUN: grant decision each cycle.
  - dbg_req=1 and (cpu_wen=0 or wait_cnt=STARVE_LIMIT): debug grant. If dbg_we=1, rf_* is driven from dbg_*. rf_dbg_raddr=dbg_addr. dbg_rdata<=rf_dbg_rdata at the edge. cpu_stall=1 only if cpu_wen=1. wait_cnt<=0. Next state is ACK.
  - Otherwise the core owns the port: rf_wen=cpu_wen, rf_waddr=cpu_waddr, rf_wdata=cpu_wdata, cpu_stall=0. If dbg_req=1, wait_cnt increments and saturates at STARVE_LIMIT.
- ACK: dbg_ack=1. The core owns the port (cpu_stall=0). No debug grant is made in this cycle; a dbg_req still high here is ignored. Next state is RUN.
- rf_wen is forced to 0 whenever rf_waddr=0 in RUN and ACK (register $0 is never written). A debug read of 0 returns rf_dbg_rdata (0).
- rf_dbg_raddr=dbg_addr in all states. Only the granted value is captured.

## Timing
- Clear sequence: 31 cycles after reset deasserts (writes 1..31). First RUN cycle is cycle 32.
- Debug latency:
  - Idle core: grant in the first RUN cycle with dbg_req=1; dbg_ack the following cycle (2 cycles from request).
  - Core writing every cycle: grant after STARVE_LIMIT waiting cycles, then ack (worst case STARVE_LIMIT+2 cycles).
- Forced grant stalls the core exactly 1 cycle. The core's write is performed in the ACK cycle because cpu_wen is held.
- Back-to-back debug requests: at most one grant every 2 cycles.
- rf_* and cpu_stall are combinational from state and inputs. dbg_ack, dbg_rdata and clearing are registered.
- Reset asserted mid-operation: all outputs take reset values asynchronously. A pending debug transaction is dropped with no ack. A debug write in flight in that cycle is not guaranteed; the clear restarts.

## Structure
- Package regfile_arb_pkg: state enum (CLEAR, RUN, ACK), REG_COUNT=32, default ADDR_W/DATA_W.
- Single module; the starvation counter and clear counter are inline. No sub-module is needed.
- The register file remains in the decode stage; only its write port and a third read port are exposed.

## Test plan
- Reset release: exactly 31 write cycles, addresses 1..31 with data 0. clearing and cpu_stall are high for those cycles and drop on cycle 32.
- Idle core: debug write addr 9, data 0x1234_5678. rf_wen is high 1 cycle; ack follows 1 cycle later. A debug read of addr 9 returns 0x1234_5678 with ack.
- Core writes every cycle with STARVE_LIMIT=4 and dbg_req high: grant occurs on the 5th cycle with cpu_stall=1 for that cycle only. The core write to addr 8 lands in the ACK cycle.
- Debug write to addr 0 (data 0xFFFF_FFFF): rf_wen=0. Ack still pulses. A subsequent debug read of 0 returns 0.
- dbg_req held high across ACK: the second grant comes no earlier than 2 cycles after the first. Exactly one ack per grant.
- reset pulled low during ACK: dbg_ack drops immediately. The clear sequence restarts from address 1 after release.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the controller state encoding and the write-port owner select.
package regfile_arb_pkg;

    localparam int REG_COUNT  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    // Wide enough for the largest starvation limit (15).
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_CLEAR = 2'd0,
        OWN_CPU   = 2'd1,
        OWN_DBG   = 2'd2
    } port_owner_t;

endpackage

// File: rtl/regfile_port_arbiter.sv
// Write-port arbiter for the decode-stage register file: clears all registers
// after reset, then shares the port between core writeback and a debug host.
module regfile_port_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_waddr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_dbg_raddr,
    input  logic [DATA_W-1:0] rf_dbg_rdata,

    output logic              clearing
);

    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(REG_COUNT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(STARVE_LIMIT);

    arb_state_t  state;
    arb_state_t  state_nxt;
    port_owner_t owner;
    logic        dbg_grant;

    logic [ADDR_W-1:0] clr_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    // Next state, grant decision and core stall.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_nxt = state;
        owner     = OWN_CPU;
        dbg_grant = 1'b0;
        cpu_stall = 1'b0;

        case (state)
            ST_CLEAR: begin
                owner     = OWN_CLEAR;
                cpu_stall = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                // An idle core yields at once; a busy core yields only once the
                // debug host has waited the full starvation limit.
                if (dbg_req && (!cpu_wen || wait_cnt == WAIT_MAX)) begin
                    dbg_grant = 1'b1;
                    owner     = OWN_DBG;
                    cpu_stall = cpu_wen;
                    state_nxt = ST_ACK;
                end
            end

            ST_ACK: begin
                state_nxt = ST_RUN;
            end

            default: begin
                owner     = OWN_CLEAR;
                cpu_stall = 1'b1;
                state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Write-port multiplexer; register 0 is never written outside the clear walk,
    // which starts at 1 anyway.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = cpu_waddr;
        rf_wdata = cpu_wdata;

        case (owner)
            OWN_CLEAR: begin
                rf_wen   = 1'b1;
                rf_waddr = clr_cnt;
                rf_wdata = '0;
            end

            OWN_DBG: begin
                rf_wen   = dbg_we && (dbg_addr != '0);
                rf_waddr = dbg_addr;
                rf_wdata = dbg_wdata;
            end

            default: begin
                rf_wen   = cpu_wen && (cpu_waddr != '0);
                rf_waddr = cpu_waddr;
                rf_wdata = cpu_wdata;
            end
        endcase
    end

    assign rf_dbg_raddr = dbg_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_CLEAR;
        end else begin
            // NOTE: non-blocking assignments, so every register samples pre-edge values.
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clr_cnt   <= CLR_FIRST;
            wait_cnt  <= '0;
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
            clearing  <= 1'b1;
        end else begin
            clearing <= (state_nxt == ST_CLEAR);
            dbg_ack  <= dbg_grant;

            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + ADDR_W'(1);
            end

            // Read data is captured only on a grant and held until the next one.
            if (dbg_grant) begin
                dbg_rdata <= rf_dbg_rdata;
                wait_cnt  <= '0;
            end else if (state == ST_RUN && dbg_req && wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-level reference model.
module tb_regfile_port_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int LIMIT  = 4;

    logic              clock;
    logic              reset;
    logic              cpu_wen;
    logic [ADDR_W-1:0] cpu_waddr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic              rf_wen;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] rf_dbg_raddr;
    logic [DATA_W-1:0] rf_dbg_rdata;
    logic              clearing;

    int n_vec = 0;
    int n_err = 0;

    // Environment register file that the DUT writes and reads.
    logic [DATA_W-1:0] bench_rf [32] = '{default: '0};

    // Reference model state.
    int                m_clr;
    bit                m_ack;
    int                m_wait;
    logic [DATA_W-1:0] m_rdata;
    logic [DATA_W-1:0] m_rf [32] = '{default: '0};
    bit                m_last_stall;
    bit                m_acked;
    bit                dbg_busy;

    regfile_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_wen     (cpu_wen),
        .cpu_waddr   (cpu_waddr),
        .cpu_wdata   (cpu_wdata),
        .cpu_stall   (cpu_stall),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_ack     (dbg_ack),
        .dbg_rdata   (dbg_rdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_dbg_raddr(rf_dbg_raddr),
        .rf_dbg_rdata(rf_dbg_rdata),
        .clearing    (clearing)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rf_wen) bench_rf[rf_waddr] <= rf_wdata;
    end

    assign rf_dbg_rdata = bench_rf[rf_dbg_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_clr        = 1;
        m_ack        = 1'b0;
        m_wait       = 0;
        m_rdata      = '0;
        m_last_stall = 1'b0;
        m_acked      = 1'b0;
        dbg_busy     = 1'b0;
    endtask

    // One clock cycle: predict from the rules, compare, then advance the model.
    // Called just after a falling edge with the inputs already driven.
    task automatic step();
        bit                in_clear;
        bit                ack_now;
        bit                grant;
        bit                e_wen;
        bit                e_stall;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic [DATA_W-1:0] captured;

        #1;
        in_clear = (m_clr <= 31);
        ack_now  = m_ack;
        grant    = !in_clear && !ack_now && dbg_req && (!cpu_wen || m_wait >= LIMIT);

        if (in_clear) begin
            e_stall = 1'b1;
            e_wen   = 1'b1;
            e_addr  = ADDR_W'(m_clr);
            e_data  = '0;
        end else if (grant) begin
            e_stall = cpu_wen;
            e_wen   = dbg_we && (dbg_addr != 0);
            e_addr  = dbg_addr;
            e_data  = dbg_wdata;
        end else begin
            e_stall = 1'b0;
            e_wen   = cpu_wen && (cpu_waddr != 0);
            e_addr  = cpu_waddr;
            e_data  = cpu_wdata;
        end

        check("clearing", clearing, in_clear);
        check("cpu_stall", cpu_stall, e_stall);
        check("dbg_ack", dbg_ack, ack_now);
        check("dbg_rdata", dbg_rdata, m_rdata);
        check("rf_wen", rf_wen, e_wen);
        if (e_wen) begin
            check("rf_waddr", rf_waddr, e_addr);
            check("rf_wdata", rf_wdata, e_data);
        end
        check("rf_dbg_raddr", rf_dbg_raddr, dbg_addr);

        captured = m_rf[dbg_addr];
        @(posedge clock);
        if (e_wen) m_rf[e_addr] = e_data;
        if (grant) m_rdata = captured;
        if (in_clear) begin
            m_clr++;
            m_wait = 0;
        end else if (grant) begin
            m_wait = 0;
        end else if (!ack_now && dbg_req && m_wait < LIMIT) begin
            m_wait++;
        end
        m_ack        = grant;
        m_acked      = ack_now;
        m_last_stall = e_stall;
        @(negedge clock);
    endtask

    task automatic idle_inputs();
        cpu_wen   = 1'b0;
        cpu_waddr = '0;
        cpu_wdata = '0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("rst_ack", dbg_ack, 1'b0);
        check("rst_rdata", dbg_rdata, 32'h0);
        check("rst_clearing", clearing, 1'b1);
        check("rst_stall", cpu_stall, 1'b1);
        check("rst_waddr", rf_waddr, 32'd1);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        m_reset();
    endtask

    // 31 clear cycles and the first RUN cycle.
    task automatic run_clear();
        idle_inputs();
        repeat (32) step();
    endtask

    task automatic dbg_set(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
    endtask

    task automatic rand_cycle(input int core_pct, input int dbg_pct);
        if (!m_last_stall) begin
            cpu_wen   = ($urandom_range(99) < core_pct);
            cpu_waddr = ADDR_W'($urandom);
            cpu_wdata = $urandom;
        end
        if (!dbg_busy) begin
            if ($urandom_range(99) < dbg_pct) begin
                dbg_set(1'($urandom), ADDR_W'($urandom), $urandom);
                dbg_busy = 1'b1;
            end else begin
                dbg_req   = 1'b0;
                dbg_we    = 1'($urandom);
                dbg_addr  = ADDR_W'($urandom);
                dbg_wdata = $urandom;
            end
        end
        step();
        if (m_acked) dbg_busy = 1'b0;
    endtask

    initial begin
        int acks;
        int core_pct [4] = '{0, 50, 90, 100};
        int dbg_pct  [4] = '{60, 80, 50, 100};

        reset = 1'b1;
        idle_inputs();
        m_reset();
        #2;
        do_reset();
        run_clear();

        // Idle core: debug write then read back register 9.
        dbg_set(1'b1, 5'd9, 32'h1234_5678);
        #1;
        check("wr9_wen", rf_wen, 1'b1);
        step();
        #1;
        check("wr9_ack", dbg_ack, 1'b1);
        check("wr9_wen_ack", rf_wen, 1'b0);
        step();
        idle_inputs();
        step();
        dbg_set(1'b0, 5'd9, 32'h0);
        step();
        #1;
        check("rd9_ack", dbg_ack, 1'b1);
        check("rd9_data", dbg_rdata, 32'h1234_5678);
        step();
        idle_inputs();
        step();

        // Busy core with a pending read: forced grant on the fifth cycle.
        cpu_wen   = 1'b1;
        cpu_waddr = 5'd8;
        cpu_wdata = 32'hCAFE_0008;
        dbg_set(1'b0, 5'd3, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("starve_stall", cpu_stall, (i == 5));
            step();
        end
        #1;
        check("starve_ack", dbg_ack, 1'b1);
        check("starve_ack_stall", cpu_stall, 1'b0);
        check("starve_core_wen", rf_wen, 1'b1);
        check("starve_core_addr", rf_waddr, 32'd8);
        step();
        idle_inputs();
        step();
        dbg_set(1'b0, 5'd8, 32'h0);
        step();
        #1;
        check("rd8_data", dbg_rdata, 32'hCAFE_0008);
        step();
        idle_inputs();
        step();

        // Register 0 is never written; a read of it returns zero.
        dbg_set(1'b1, 5'd0, 32'hFFFF_FFFF);
        #1;
        check("wr0_wen", rf_wen, 1'b0);
        step();
        #1;
        check("wr0_ack", dbg_ack, 1'b1);
        step();
        idle_inputs();
        step();
        dbg_set(1'b0, 5'd0, 32'h0);
        step();
        #1;
        check("rd0_data", dbg_rdata, 32'h0);
        step();
        idle_inputs();
        step();

        // Request held high: one grant every two cycles, one ack per grant.
        acks = 0;
        dbg_set(1'b1, 5'd5, 32'h0000_0A55);
        for (int i = 0; i < 10; i++) begin
            #1;
            if (dbg_ack) acks++;
            step();
        end
        check("b2b_acks", acks, 32'd5);
        idle_inputs();
        step();

        // Reset during the ACK cycle drops the ack and restarts the clear walk.
        dbg_set(1'b1, 5'd12, 32'h0BAD_F00D);
        step();
        #1;
        check("rack_pre", dbg_ack, 1'b1);
        do_reset();
        run_clear();

        // Randomized traffic across several core/debug load mixes.
        for (int p = 0; p < 4; p++) begin
            for (int n = 0; n < 500; n++) rand_cycle(core_pct[p], dbg_pct[p]);
        end

        // Drain any open transaction so the read-back below is not disturbed.
        repeat (4) rand_cycle(0, 0);
        idle_inputs();
        step();

        // Read every register back and compare with the model's contents.
        for (int r = 0; r < 32; r++) begin
            dbg_set(1'b0, ADDR_W'(r), 32'h0);
            step();
            step();
            idle_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
